// File: rtl/bit_index_iter.sv
// Iterates over the set bits of an accepted word, emitting one bit index per handshake, LSB first.
// Optional remaining-beat count output dout_left is enabled by defining BIT_INDEX_ITER_CNT_EN.
module bit_index_iter #(
    parameter  int unsigned DATA_WIDTH = 32,
    localparam int unsigned IDX_W      = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic [IDX_W-1:0]      dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
`ifdef BIT_INDEX_ITER_CNT_EN
    output logic [IDX_W-1:0]      dout_left,
`endif
    output logic                  dout_last
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ITER = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [IDX_W-1:0]      dout_q, dout_d;
    logic                  last_q, last_d;
    logic                  fire;
    logic                  accept;

    // Trailing-zero count; an all-zero word maps to DATA_WIDTH.
    function automatic logic [IDX_W-1:0] ctz(input logic [DATA_WIDTH-1:0] w);
        logic [IDX_W-1:0] idx;
        idx = IDX_W'(DATA_WIDTH);
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            if (w[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

`ifdef BIT_INDEX_ITER_CNT_EN
    logic [IDX_W-1:0] left_q, left_d;

    function automatic logic [IDX_W-1:0] popcount(input logic [DATA_WIDTH-1:0] w);
        logic [IDX_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            cnt = cnt + IDX_W'(w[i]);
        end
        return cnt;
    endfunction
`endif

    // Next-state and next-output computation; outputs are registered from the next held word.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        dout_d  = '0;
        last_d  = 1'b0;
`ifdef BIT_INDEX_ITER_CNT_EN
        left_d  = '0;
`endif

        fire      = (state_q == ITER) && dout_ready;
        din_ready = (state_q == IDLE) || (fire && last_q);
        accept    = din_valid && din_ready;

        if (accept) begin
            state_d = ITER;
            word_d  = din;
        end else if (fire && last_q) begin
            state_d = IDLE;
            word_d  = '0;
        end else if (fire) begin
            word_d  = word_q & (word_q - DATA_WIDTH'(1));
        end

        if (state_d == ITER) begin
            dout_d = ctz(word_d);
            // Zero or one set bit remaining means this is the final beat.
            last_d = ((word_d & (word_d - DATA_WIDTH'(1))) == '0);
`ifdef BIT_INDEX_ITER_CNT_EN
            left_d = popcount(word_d);
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            word_q  <= '0;
            dout_q  <= '0;
            last_q  <= 1'b0;
`ifdef BIT_INDEX_ITER_CNT_EN
            left_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            dout_q  <= dout_d;
            last_q  <= last_d;
`ifdef BIT_INDEX_ITER_CNT_EN
            left_q  <= left_d;
`endif
        end
    end

    assign dout_valid = (state_q == ITER);
    assign dout       = dout_q;
    assign dout_last  = last_q;
`ifdef BIT_INDEX_ITER_CNT_EN
    assign dout_left  = left_q;
`endif

endmodule

// File: doc/bit_index_iter.md
BIT_INDEX_ITER -- requirements
Module: bit_index_iter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the input word width in bits.
REQ-002 The block SHALL use index width IDX_W = $clog2(DATA_WIDTH)+1 for all index outputs.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset, asynchronous and active-high.
REQ-005 din  input  DATA_WIDTH  word to iterate over.
REQ-006 din_valid  input  1  din is presented.
REQ-007 din_ready  output  1  block accepts din this cycle.
REQ-008 dout  output  IDX_W  bit index of the lowest remaining set bit (trailing-zero count of the held word).
REQ-009 dout_valid  output  1  dout is valid.
REQ-010 dout_ready  input  1  downstream accepts dout this cycle.
REQ-011 dout_last  output  1  current dout is the final beat for the held word.

Function
REQ-012 The block SHALL implement two states: IDLE (no word held) and ITER (word held, emitting indices).
REQ-013 A word SHALL be accepted when din_valid && din_ready; it is captured into the held-word register.
REQ-014 din_ready SHALL be 1 in IDLE, and 1 in ITER only in a cycle where dout_valid && dout_ready && dout_last.
REQ-015 Transition IDLE->ITER SHALL occur on acceptance; dout_valid SHALL rise the cycle after acceptance (latency 1 cycle).
REQ-016 In ITER, dout_valid SHALL be 1 and dout SHALL equal the index of the lowest set bit of the held word.
REQ-017 If the held word is all zeros, dout SHALL equal DATA_WIDTH and dout_last SHALL be 1 (exactly one beat).
REQ-018 dout_last SHALL be 1 when the held word has zero or exactly one set bit, else 0.
REQ-019 On dout_valid && dout_ready with dout_last=0, the held word SHALL become word & (word-1) (lowest set bit cleared); state stays ITER.
REQ-020 On dout_valid && dout_ready with dout_last=1 and no simultaneous acceptance, state SHALL return to IDLE and dout_valid SHALL drop next cycle.
REQ-021 On dout_valid && dout_ready && dout_last with simultaneous acceptance, the new word SHALL load, state stays ITER, no bubble cycle.
REQ-022 While dout_valid && !dout_ready, dout, dout_last and the held word SHALL remain stable.
REQ-023 Indices SHALL be emitted strictly ascending, LSB first, one per handshake; din is ignored when din_ready=0.
REQ-024 In IDLE, dout and dout_last SHALL be 0.

Reset
REQ-025 While reset is high, state SHALL be IDLE, held word 0, dout_valid 0, dout 0, dout_last 0, din_ready 1.
REQ-026 Reset asserted mid-iteration SHALL discard the held word immediately (asynchronously); no remaining indices are emitted after release.
REQ-027 The first acceptance SHALL be possible on the first rising edge after reset deasserts.

Configuration
REQ-028 Macro BIT_INDEX_ITER_CNT_EN SHALL control an extra output dout_left (output, IDX_W).
REQ-029 With BIT_INDEX_ITER_CNT_EN defined, dout_left SHALL equal the popcount of the held word (beats remaining including current) in ITER; it is 0 for an all-zero held word and in IDLE/reset.
REQ-030 Without BIT_INDEX_ITER_CNT_EN, the port and its popcount logic SHALL be absent; all other behaviour is identical.

Verification (DATA_WIDTH=32)
REQ-031 din=0x00000016, dout_ready=1 -> dout 1,2,4 on three consecutive cycles, dout_last only on 4; dout_left 3,2,1 when CNT_EN.
REQ-032 din=0x00000000 -> single beat dout=32, dout_last=1, then IDLE.
REQ-033 din=0x80000000 -> single beat dout=31, dout_last=1.
REQ-034 din=0x00000005, dout_ready low 3 cycles -> dout holds 0 stable with dout_valid=1, then 0, 2 after ready rises.
REQ-035 din=0x00000003 then 0x00000001 held on din_valid -> second word accepted on the last-beat handshake; dout 0,1,0 on consecutive cycles, no gap.
REQ-036 din=0x000000FF, reset pulsed after two beats -> dout_valid=0 and din_ready=1 during reset; no further indices after release.
